// File: rtl/tr_timing_seq_if.sv
// Bus bundle for the transmit/receive timing sequencer: config, DDS events, switch controls.
interface tr_timing_seq_if #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned GUARD_W = 8,
  parameter int unsigned N_RX    = 3,
  parameter int unsigned PCNT_W  = 16
);
  logic [CNT_W-1:0]   ct_period;
  logic [GUARD_W-1:0] tv_guard;
  logic [GUARD_W-1:0] pwr_guard;
  logic [1:0]         tv_mode;
  logic               upd_sweep;
  logic               upd_ct;
  logic               trig;
  logic               pre_trig;
  logic               osk_in;
  logic [N_RX-1:0]    rx_pwr_ctrl;
  logic               osk_out;
  logic               tr;
  logic               lo;
  logic               tr_pwr;
  logic               tv;
  logic [N_RX-1:0]    rx_ch_ctrl;
  logic               ct_active;
  logic [PCNT_W-1:0]  pulse_cnt;

  modport master (
    output ct_period, tv_guard, pwr_guard, tv_mode, upd_sweep, upd_ct, trig, pre_trig,
           osk_in, rx_pwr_ctrl,
    input  osk_out, tr, lo, tr_pwr, tv, rx_ch_ctrl, ct_active, pulse_cnt
  );

  modport slave (
    input  ct_period, tv_guard, pwr_guard, tv_mode, upd_sweep, upd_ct, trig, pre_trig,
           osk_in, rx_pwr_ctrl,
    output osk_out, tr, lo, tr_pwr, tv, rx_ch_ctrl, ct_active, pulse_cnt
  );
endinterface

// File: rtl/tr_timing_seq.sv
// Transmit/receive timing sequencer: CT window, T/R + polarisation switching, TR power sequencing.
module tr_timing_seq #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned GUARD_W     = 8,
  parameter int unsigned N_RX        = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PCNT_W      = 16
) (
  input logic             clk,
  input logic             rst,
  tr_timing_seq_if.slave  bus
);

  localparam int unsigned N_ASYNC = 4;

  typedef enum logic [0:0] {CT_IDLE, CT_ACTIVE} ct_state_t;
  typedef enum logic [0:0] {SW_IDLE, SW_SETTLE} sw_state_t;
  typedef enum logic [1:0] {PW_OFF, PW_WAIT, PW_ON} pw_state_t;

  // bit order: {pre_trig, trig, upd_ct, upd_sweep}
  logic [N_ASYNC-1:0] async_in;
  logic [N_ASYNC-1:0] sync_q [SYNC_STAGES];
  logic [N_ASYNC-1:0] edge_q;
  logic [N_ASYNC-1:0] cur;
  logic               sweep_rise, ct_rise, trig_fall, pre_rise;

  ct_state_t          ct_state;
  logic [CNT_W-1:0]   ct_cnt;
  logic [CNT_W-1:0]   ct_period_q;
  logic               ct_active_q;
  logic               ct_end;

  sw_state_t          sw_state;
  logic [GUARD_W-1:0] sw_cnt;
  logic [GUARD_W-1:0] tv_guard_q;
  logic               tv_q;
  logic               tr_q;
  logic [PCNT_W-1:0]  pulse_cnt_q;

  pw_state_t          pw_state;
  logic [GUARD_W-1:0] pw_cnt;
  logic [GUARD_W-1:0] pwr_guard_q;
  logic               tr_pwr_q;

  assign async_in = {bus.pre_trig, bus.trig, bus.upd_ct, bus.upd_sweep};

  // Synchroniser chain per async input plus one edge-detect flop
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      edge_q <= '0;
    end else begin
      sync_q[0] <= async_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign cur        = sync_q[SYNC_STAGES-1];
  assign sweep_rise = cur[0] & ~edge_q[0];
  assign ct_rise    = cur[1] & ~edge_q[1];
  assign trig_fall  = ~cur[2] & edge_q[2];
  assign pre_rise   = cur[3] & ~edge_q[3];

  // Window closes on this edge unless a retrigger restarts it
  assign ct_end = (ct_state == CT_ACTIVE) && (ct_cnt == ct_period_q) && !ct_rise;

  // CT window FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      ct_state    <= CT_IDLE;
      ct_cnt      <= '0;
      ct_period_q <= '0;
      ct_active_q <= 1'b0;
    end else if (ct_rise) begin
      ct_state    <= CT_ACTIVE;
      ct_cnt      <= '0;
      ct_period_q <= bus.ct_period;
      ct_active_q <= 1'b1;
    end else if (ct_state == CT_ACTIVE) begin
      if (ct_cnt == ct_period_q) begin
        ct_state    <= CT_IDLE;
        ct_active_q <= 1'b0;
      end else begin
        ct_cnt <= ct_cnt + CNT_W'(1);
      end
    end
  end

  // Switch FSM: settle after sweep/pre-trigger, then update tv/tr and count pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_state    <= SW_IDLE;
      sw_cnt      <= '0;
      tv_guard_q  <= '0;
      tv_q        <= 1'b1;
      tr_q        <= 1'b0;
      pulse_cnt_q <= '0;
    end else begin
      if (sweep_rise || pre_rise) begin
        if (sweep_rise) tv_q <= 1'b1;
        sw_state   <= SW_SETTLE;
        sw_cnt     <= '0;
        tv_guard_q <= bus.tv_guard;
      end else if (sw_state == SW_SETTLE) begin
        if (sw_cnt == tv_guard_q) begin
          sw_state <= SW_IDLE;
          case (bus.tv_mode)
            2'b00:   tv_q <= 1'b0;
            2'b01:   tv_q <= 1'b1;
            default: tv_q <= ~tv_q;
          endcase
          tr_q <= ct_active_q;
          if (ct_active_q && (pulse_cnt_q != '1)) pulse_cnt_q <= pulse_cnt_q + PCNT_W'(1);
        end else begin
          sw_cnt <= sw_cnt + GUARD_W'(1);
        end
      end
      // tr never outlives the CT window; a new window starts a fresh pulse count
      if (ct_end)  tr_q        <= 1'b0;
      if (ct_rise) pulse_cnt_q <= '0;
    end
  end

  // TR power FSM: power-on delay after sweep/pre-trigger, off on trigger fall
  always_ff @(posedge clk) begin
    if (!rst) begin
      pw_state    <= PW_OFF;
      pw_cnt      <= '0;
      pwr_guard_q <= '0;
      tr_pwr_q    <= 1'b0;
    end else if (sweep_rise || pre_rise) begin
      pw_state    <= PW_WAIT;
      pw_cnt      <= '0;
      pwr_guard_q <= bus.pwr_guard;
      tr_pwr_q    <= 1'b0;
    end else if (trig_fall) begin
      pw_state <= PW_OFF;
      tr_pwr_q <= 1'b0;
    end else begin
      case (pw_state)
        PW_WAIT: begin
          if (pw_cnt == pwr_guard_q) begin
            pw_state <= PW_ON;
            tr_pwr_q <= 1'b1;
          end else begin
            pw_cnt <= pw_cnt + GUARD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ct_active  = ct_active_q;
  assign bus.tr         = tr_q;
  assign bus.lo         = tr_q;
  assign bus.tv         = tv_q;
  assign bus.tr_pwr     = tr_pwr_q;
  assign bus.pulse_cnt  = pulse_cnt_q;
  assign bus.osk_out    = ct_active_q & bus.osk_in;
  assign bus.rx_ch_ctrl = ct_active_q ? bus.rx_pwr_ctrl : '0;

endmodule

// File: doc/tr_timing_seq.md
Name: tr_timing_seq

Overview:
- Parametrised transmit/receive timing sequencer; next generation of the DDS-driven CT/TV/TR work-flow block.
- Sits between the AD9914 sweep/trigger outputs and the RF front-end switch controls.
- Adds over the previous generation: run-time programmable guard times, N receive channels, configurable input synchroniser depth, explicit polarisation modes, and a per-CT pulse counter.

Parameters:
CNT_W, 32, width of ct_period and the CT window counter
GUARD_W, 8, width of the tv_guard/pwr_guard settle counters
N_RX, 3, number of receive-channel power controls
SYNC_STAGES, 2, synchroniser flops per async input (min 1)
PCNT_W, 16, width of pulse_cnt

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
ct_period  in  CNT_W  CT window length; latched on upd_ct rise
tv_guard  in  GUARD_W  TV/TR settle delay in cycles; sampled when the settle counter starts
pwr_guard  in  GUARD_W  TR power-on delay in cycles; sampled when the power counter starts
tv_mode  in  2  00 H fixed, 01 V fixed, 1x alternate
upd_sweep  in  1  DDS1 update (async)
upd_ct  in  1  DDS2 update (async)
trig  in  1  DDS1 trigger (async)
pre_trig  in  1  DDS1 pre-trigger (async)
osk_in  in  1  DDS2 OSK request
rx_pwr_ctrl  in  N_RX  receive-channel enables
osk_out  out  1  osk_in gated by ct_active
tr  out  1  T/R switch
lo  out  1  LO switch, equals tr
tr_pwr  out  1  TR power enable
tv  out  1  polarisation select
rx_ch_ctrl  out  N_RX  rx_pwr_ctrl gated by ct_active
ct_active  out  1  CT window open
pulse_cnt  out  PCNT_W  settle completions in the current CT window

Behaviour:
- Reset values (rst=0 at posedge): ct_active=0, tr=0, lo=0, tr_pwr=0, tv=1, pulse_cnt=0, all counters=0, all FSMs in IDLE/OFF, synchroniser and edge flops=0.
- Synchronisation: each async input passes through SYNC_STAGES flops, then one edge flop.
  - Rise event = prev 0 / cur 1; fall event = prev 1 / cur 0.
  - Each event is a one-cycle internal pulse, valid SYNC_STAGES+1 cycles after the input first meets setup.
- CT FSM (IDLE, ACTIVE):
  - upd_ct rise: ACTIVE, ct_active=1, latch ct_period, cnt=0, pulse_cnt=0. Retrigger while ACTIVE restarts the window identically.
  - ACTIVE: cnt increments each cycle. When cnt==latched period, go to IDLE and ct_active=0 on the next edge.
  - Result: ct_active is high exactly period+1 cycles; period=0 gives 1 cycle.
- Switch FSM (IDLE, SETTLE):
  - upd_sweep rise: tv=1, swcnt=0, SETTLE.
  - pre_trig rise: swcnt=0, SETTLE, tv unchanged.
  - If upd_sweep and pre_trig rise in the same cycle, upd_sweep wins.
  - SETTLE: swcnt increments. At swcnt==tv_guard (sampled value), go to IDLE and, on that edge:
    - tv: 0 for mode 00, 1 for mode 01, toggled for mode 1x.
    - tr = ct_active.
    - pulse_cnt += 1 if ct_active, saturating at all-ones.
  - tv/tr therefore update tv_guard+1 cycles after the event cycle.
  - ct_active falling clears tr on the same edge. This is new behaviour: tr never outlives the CT window.
- Power FSM (OFF, WAIT, ON):
  - upd_sweep or pre_trig rise: tr_pwr=0, pcnt=0, WAIT.
  - trig fall: tr_pwr=0, OFF.
  - Priority: rise events > trig fall.
  - WAIT: pcnt increments. At pcnt==pwr_guard, tr_pwr=1, ON.
- Combinational outputs:
  - lo = tr.
  - osk_out = ct_active & osk_in.
  - rx_ch_ctrl = ct_active ? rx_pwr_ctrl : 0.
- Counter wraps: the CT cnt never wraps, because the terminal compare occurs first at any period value.
- Reset mid-operation aborts all FSMs to their reset state on that edge.

Test Plan:
1. SYNC_STAGES=2, ct_period=5, pulse upd_ct -> ct_active rises 3 cycles after the input and stays high exactly 6 cycles; osk_out follows osk_in only during that window; rx_pwr_ctrl=3'b101 appears on rx_ch_ctrl only while ct_active=1.
2. tv_mode=11, tv_guard=10, upd_sweep then 3 pre_trig pulses spaced 40 cycles, ct_active held high -> tv goes 1→0→1→0→1, each toggle 11 cycles after its event; tr=lo=1; pulse_cnt=4.
3. pwr_guard=20, pre_trig rise -> tr_pwr=1 21 cycles after the event; trig fall -> tr_pwr=0 the next cycle; trig fall in the same cycle as a pre_trig rise -> WAIT restarts and tr_pwr stays 0.
4. ct_period=0 -> ct_active high 1 cycle. Retrigger upd_ct at cnt=3 of a period=10 window -> window extends to 11 cycles from the retrigger; pulse_cnt cleared.
5. ct_active falls while tr=1 -> tr and lo go to 0 on the same edge. With mode 00/01, tv settles to 0/1 after the guard.
6. Assert rst=0 mid-SETTLE and mid-CT -> next cycle all outputs at reset values (tv=1, others 0); the first event after release behaves as from power-up.
